// File: rtl/axil_reg_slave.sv
// AXI4-Lite register file: NUM_REGS x DATA_W registers with byte strobes,
// independent one-deep AW/W buffers, read-only slots mirrored from hw_d.
module axil_reg_slave #(
    parameter int                    ADDR_W   = 32,
    parameter int                    DATA_W   = 32,
    parameter int                    NUM_REGS = 8,
    parameter logic [NUM_REGS-1:0]   RO_MASK  = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       awvalid,
    output logic                       awready,
    input  logic [ADDR_W-1:0]          awaddr,

    input  logic                       wvalid,
    output logic                       wready,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [DATA_W/8-1:0]        wstrb,

    output logic                       bvalid,
    input  logic                       bready,
    output logic [1:0]                 bresp,

    input  logic                       arvalid,
    output logic                       arready,
    input  logic [ADDR_W-1:0]          araddr,

    output logic                       rvalid,
    input  logic                       rready,
    output logic [DATA_W-1:0]          rdata,
    output logic [1:0]                 rresp,

    output logic [NUM_REGS*DATA_W-1:0] reg_q,
    input  logic [NUM_REGS*DATA_W-1:0] hw_d,
    output logic [NUM_REGS-1:0]        wr_pulse
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_W - OFF_W;
    localparam int SEL_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    // One extra bit so NUM_REGS itself is representable in the range compare.
    localparam logic [IDX_W:0] NUM_REGS_W = (IDX_W + 1)'(NUM_REGS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // Valid is never withdrawn by this slave until the matching ready, and
    // every ready/valid output here comes straight from a flop.

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return {1'b0, addr[ADDR_W-1:OFF_W]} < NUM_REGS_W;
    endfunction

    function automatic logic [SEL_W-1:0] slot_of(input logic [ADDR_W-1:0] addr);
        return addr[OFF_W +: SEL_W];
    endfunction

    // ------------------------------------------------------------------
    // Write address / data buffers
    // ------------------------------------------------------------------
    logic                 aw_full;
    logic [ADDR_W-1:0]    aw_addr;
    logic                 w_full;
    logic [DATA_W-1:0]    w_data;
    logic [STRB_W-1:0]    w_strb;

    logic                 commit;
    logic                 wr_ok;
    logic [SEL_W-1:0]     wr_sel;
    logic [NUM_REGS-1:0]  slot_we;

    logic [DATA_W-1:0]    regs [NUM_REGS];

    assign awready = !aw_full;
    assign wready  = !w_full;
    assign commit  = aw_full && w_full && !bvalid;
    assign wr_sel  = slot_of(aw_addr);
    assign wr_ok   = in_range(aw_addr) && !RO_MASK[wr_sel];

    always_comb begin
        slot_we = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            slot_we[i] = commit && wr_ok && (wr_sel == SEL_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_full <= 1'b0;
            aw_addr <= '0;
            w_full  <= 1'b0;
            w_data  <= '0;
            w_strb  <= '0;
        end else begin
            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
            end
            if (awvalid && awready) begin
                aw_full <= 1'b1;
                aw_addr <= awaddr;
            end
            if (wvalid && wready) begin
                w_full <= 1'b1;
                w_data <= wdata;
                w_strb <= wstrb;
            end
        end
    end

    // ------------------------------------------------------------------
    // Write response
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bvalid <= 1'b0;
            bresp  <= RESP_OKAY;
        end else if (commit) begin
            bvalid <= 1'b1;
            bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid && bready) begin
            bvalid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Register storage and per-slot write pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            wr_pulse <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                wr_pulse[i] <= slot_we[i];
                if (slot_we[i]) begin
                    for (int j = 0; j < STRB_W; j++) begin
                        if (w_strb[j]) begin
                            regs[i][8*j +: 8] <= w_data[8*j +: 8];
                        end
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
        assign reg_q[g*DATA_W +: DATA_W] = regs[g];
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic              ar_ok;
    logic [SEL_W-1:0]  ar_sel;
    logic [DATA_W-1:0] rd_word;

    assign arready = !rvalid;
    assign ar_ok   = in_range(araddr);
    assign ar_sel  = slot_of(araddr);

    // regs[] is read before any same-edge commit lands, so reads see the old value.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_sel == SEL_W'(i)) begin
                rd_word = RO_MASK[i] ? hw_d[i*DATA_W +: DATA_W] : regs[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
        end else if (arvalid && arready) begin
            rvalid <= 1'b1;
            rdata  <= ar_ok ? rd_word : '0;
            rresp  <= ar_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid && rready) begin
            rvalid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------
    a_b_hold : assert property (@(posedge clk) disable iff (!rst_n)
        bvalid && !bready |=> bvalid && $stable(bresp));

    a_r_hold : assert property (@(posedge clk) disable iff (!rst_n)
        rvalid && !rready |=> rvalid && $stable(rdata) && $stable(rresp));

    a_pulse_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(wr_pulse));

endmodule
